// File: rtl/mem_pkg.sv
// Shared definitions for the memory responder and the control FSM:
// FSM state encoding, default widths and load/store opcodes.
package mem_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int ADDR_W_DEF = 8;

    localparam logic [3:0] OP_LOAD  = 4'b0010;
    localparam logic [3:0] OP_STORE = 4'b0011;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT     = 2'd1,
        COMPLETE = 2'd2
    } state_t;

endpackage

// File: rtl/mem_if.sv
// Control/bus bundle between the memory FSM (master) and the memory
// responder (slave): bus, MAR/MDR strobes, access request, status.
interface mem_if #(
    parameter int DATA_W = 16
);
    logic [DATA_W-1:0] bus_in;
    logic              mar_in;
    logic              mdr_write_en;
    logic              mdr_read_en;
    logic              mdr_out;
    logic              mem_en;
    logic              rw;
    logic [DATA_W-1:0] bus_out;
    logic              bus_out_en;
    logic              mem_ready;
    logic              busy;
    logic [DATA_W-1:0] mar_q;
    logic [DATA_W-1:0] mdr_q;

    modport master (
        output bus_in, mar_in, mdr_write_en, mdr_read_en,
        output mdr_out, mem_en, rw,
        input  bus_out, bus_out_en, mem_ready, busy, mar_q, mdr_q
    );

    modport slave (
        input  bus_in, mar_in, mdr_write_en, mdr_read_en,
        input  mdr_out, mem_en, rw,
        output bus_out, bus_out_en, mem_ready, busy, mar_q, mdr_q
    );
endinterface

// File: rtl/mem_array.sv
// Synchronous single-port RAM. Ports: clk, rst, we, re, addr, wdata, rdata.
// rdata is registered, updated only on a read and holds otherwise.
module mem_array #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [DEPTH];

    // Storage itself is never reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    // rdata doubles as the responder's read buffer, so it holds its value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[addr];
        end
    end
endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: MAR, MDR, read buffer and timed RAM access.
// Ports: clk, rst (async, active-high), bus (mem_if.slave bundle).
module mem_responder
    import mem_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DEPTH       = 2 ** ADDR_W,
    parameter int WAIT_CYCLES = 2
) (
    input logic  clk,
    input logic  rst,
    mem_if.slave bus
);
    localparam bit         ZERO_WAIT = (WAIT_CYCLES == 0);
    localparam logic [3:0] CNT_INIT  =
        ZERO_WAIT ? 4'd0 : 4'(WAIT_CYCLES - 1);

    state_t            state;
    state_t            state_nxt;
    logic [3:0]        cnt;
    logic [3:0]        cnt_nxt;
    logic              accept;
    logic              commit;

    logic [DATA_W-1:0] mar;
    logic [DATA_W-1:0] mdr;
    logic [DATA_W-1:0] rbuf;

    logic              op_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;

    logic              op_c;
    logic [ADDR_W-1:0] addr_c;
    logic [DATA_W-1:0] wdata_c;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        accept    = 1'b0;
        commit    = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.mem_en) begin
                    accept = 1'b1;
                    if (ZERO_WAIT) begin
                        state_nxt = COMPLETE;
                        commit    = 1'b1;
                    end else begin
                        state_nxt = WAIT;
                        cnt_nxt   = CNT_INIT;
                    end
                end
            end
            WAIT: begin
                if (cnt == 4'd0) begin
                    state_nxt = COMPLETE;
                    commit    = 1'b1;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            COMPLETE: state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // A zero-wait commit happens on the accept edge, before the
    // snapshot registers hold anything, so use the live values then.
    assign op_c    = (state == IDLE) ? bus.rw : op_q;
    assign addr_c  = (state == IDLE) ? mar[ADDR_W-1:0] : addr_q;
    assign wdata_c = (state == IDLE) ? mdr : wdata_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (accept) begin
            op_q    <= bus.rw;
            addr_q  <= mar[ADDR_W-1:0];
            wdata_q <= mdr;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mar <= '0;
        end else if (bus.mar_in) begin
            mar <= bus.bus_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mdr <= '0;
        end else if (bus.mdr_write_en) begin
            mdr <= bus.bus_in;
        end else if (bus.mdr_read_en) begin
            mdr <= rbuf;
        end
    end

    mem_array #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_array (
        .clk   (clk),
        .rst   (rst),
        .we    (commit & op_c),
        .re    (commit & ~op_c),
        .addr  (addr_c),
        .wdata (wdata_c),
        .rdata (rbuf)
    );

    assign bus.bus_out    = bus.mdr_out ? mdr : '0;
    assign bus.bus_out_en = bus.mdr_out;
    assign bus.mem_ready  = (state == COMPLETE);
    assign bus.busy       = (state != IDLE);
    assign bus.mar_q      = mar;
    assign bus.mdr_q      = mdr;
endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: a WAIT_CYCLES=2 instance and a
// WAIT_CYCLES=0 instance sharing clock and reset.
module tb_mem_responder;
    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   ready_cnt;

    mem_if #(.DATA_W(16)) bus ();
    mem_if #(.DATA_W(16)) bus0 ();

    mem_responder #(.WAIT_CYCLES(2)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    mem_responder #(.WAIT_CYCLES(0)) u_dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.mem_ready === 1'b1) ready_cnt++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag,
                         input logic [15:0] obs,
                         input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc;
        @(negedge clk);
    endtask

    task automatic set_mar(input logic [15:0] v);
        bus.bus_in = v;
        bus.mar_in = 1'b1;
        cyc();
        bus.mar_in = 1'b0;
        bus.bus_in = '0;
    endtask

    task automatic set_mdr(input logic [15:0] v);
        bus.bus_in       = v;
        bus.mdr_write_en = 1'b1;
        cyc();
        bus.mdr_write_en = 1'b0;
        bus.bus_in       = '0;
    endtask

    // Ends on the negedge where mem_ready is seen (or the bound).
    task automatic access(input logic w, output int lat, output int bn);
        bus.rw     = w;
        bus.mem_en = 1'b1;
        cyc();
        bus.mem_en = 1'b0;
        bus.rw     = 1'b0;
        lat = 1;
        bn  = 0;
        while (bus.mem_ready !== 1'b1 && lat < 20) begin
            if (bus.busy === 1'b1) bn++;
            cyc();
            lat++;
        end
        if (bus.busy === 1'b1) bn++;
    endtask

    task automatic store(input logic [15:0] a, input logic [15:0] d);
        int lat;
        int bn;
        set_mar(a);
        set_mdr(d);
        access(1'b1, lat, bn);
        cyc();
    endtask

    task automatic load_chk(input string tag,
                            input logic [15:0] a,
                            input logic [15:0] exp);
        int lat;
        int bn;
        set_mar(a);
        access(1'b0, lat, bn);
        bus.mdr_read_en = 1'b1;
        cyc();
        bus.mdr_read_en = 1'b0;
        check(tag, bus.mdr_q, exp);
    endtask

    initial begin
        int lat;
        int bn;
        int r0;
        checks    = 0;
        errors    = 0;
        ready_cnt = 0;
        rst       = 1'b1;
        bus.bus_in = '0;  bus.mar_in = 0; bus.mdr_write_en = 0;
        bus.mdr_read_en = 0; bus.mdr_out = 0; bus.mem_en = 0; bus.rw = 0;
        bus0.bus_in = '0; bus0.mar_in = 0; bus0.mdr_write_en = 0;
        bus0.mdr_read_en = 0; bus0.mdr_out = 0; bus0.mem_en = 0;
        bus0.rw = 0;
        repeat (2) cyc();
        rst = 1'b0;

        // Load registers, then reset asynchronously mid-cycle.
        set_mar(16'h0055);
        set_mdr(16'h0066);
        check("pre_rst_mar", bus.mar_q, 16'h0055);
        check("pre_rst_mdr", bus.mdr_q, 16'h0066);
        @(posedge clk);
        #3;
        rst = 1'b1;
        bus.mdr_out = 1'b1;
        #1;
        check("rst_mar", bus.mar_q, 16'h0000);
        check("rst_mdr", bus.mdr_q, 16'h0000);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_ready", bus.mem_ready, 1'b0);
        check("rst_bus_out", bus.bus_out, 16'h0000);
        check("rst_bus_out_en", bus.bus_out_en, 1'b1);
        bus.mdr_out = 1'b0;
        cyc();
        rst = 1'b0;
        cyc();

        // Store 0xBEEF to address 5: latency and busy duration.
        set_mar(16'h0005);
        set_mdr(16'hBEEF);
        access(1'b1, lat, bn);
        check("store_latency", 16'(lat), 16'd3);
        check("store_busy_cycles", 16'(bn), 16'd3);
        cyc();
        check("ready_pulse_end", bus.mem_ready, 1'b0);
        check("busy_end", bus.busy, 1'b0);

        // Load with read buffer capture in the ready cycle, then drive.
        store(16'h0007, 16'h1234);
        set_mdr(16'h0000);
        check("mdr_cleared", bus.mdr_q, 16'h0000);
        load_chk("load_7", 16'h0007, 16'h1234);
        bus.mdr_out = 1'b1;
        #1;
        check("bus_out_load", bus.bus_out, 16'h1234);
        check("bus_out_en_load", bus.bus_out_en, 1'b1);
        bus.mdr_out = 1'b0;
        #1;
        check("bus_out_off", bus.bus_out, 16'h0000);
        cyc();
        load_chk("load_5", 16'h0005, 16'hBEEF);

        // Isolation: change MAR/MDR/rw and pulse mem_en mid-access.
        store(16'h0009, 16'h9999);
        set_mar(16'h0003);
        set_mdr(16'hC3C3);
        r0 = ready_cnt;
        bus.rw     = 1'b1;
        bus.mem_en = 1'b1;
        cyc();
        bus.mem_en = 1'b0;
        bus.rw     = 1'b0;
        bus.bus_in = 16'h0009;
        bus.mar_in = 1'b1;
        cyc();
        bus.mar_in       = 1'b0;
        bus.bus_in       = 16'hAAAA;
        bus.mdr_write_en = 1'b1;
        bus.mem_en       = 1'b1;
        cyc();
        check("iso_ready", bus.mem_ready, 1'b1);
        bus.mdr_write_en = 1'b0;
        bus.bus_in       = '0;
        cyc();
        bus.mem_en = 1'b0;
        check("iso_ignored_busy", bus.busy, 1'b0);
        repeat (4) cyc();
        check("iso_ready_count", 16'(ready_cnt - r0), 16'd1);
        check("iso_mar", bus.mar_q, 16'h0009);
        check("iso_mdr", bus.mdr_q, 16'hAAAA);
        load_chk("iso_ram3", 16'h0003, 16'hC3C3);
        load_chk("iso_ram9", 16'h0009, 16'h9999);

        // Address wrap and MDR load priority.
        store(16'h0105, 16'h00FF);
        load_chk("wrap_ram5", 16'h0005, 16'h00FF);
        bus.bus_in       = 16'h5A5A;
        bus.mdr_write_en = 1'b1;
        bus.mdr_read_en  = 1'b1;
        cyc();
        bus.mdr_write_en = 1'b0;
        bus.mdr_read_en  = 1'b0;
        bus.bus_in       = '0;
        check("mdr_priority", bus.mdr_q, 16'h5A5A);

        // Reset during WAIT of a store leaves RAM untouched.
        store(16'h0002, 16'h1111);
        set_mar(16'h0002);
        set_mdr(16'h7777);
        r0 = ready_cnt;
        bus.rw     = 1'b1;
        bus.mem_en = 1'b1;
        cyc();
        bus.mem_en = 1'b0;
        bus.rw     = 1'b0;
        check("midrst_busy_before", bus.busy, 1'b1);
        #1;
        rst = 1'b1;
        #1;
        check("midrst_busy", bus.busy, 1'b0);
        rst = 1'b0;
        repeat (6) cyc();
        check("midrst_no_ready", 16'(ready_cnt - r0), 16'd0);
        load_chk("midrst_ram2", 16'h0002, 16'h1111);

        // Zero wait states: ready in the cycle after mem_en.
        bus0.bus_in = 16'h0004;
        bus0.mar_in = 1'b1;
        cyc();
        bus0.mar_in       = 1'b0;
        bus0.bus_in       = 16'h4242;
        bus0.mdr_write_en = 1'b1;
        cyc();
        bus0.mdr_write_en = 1'b0;
        bus0.bus_in       = '0;
        bus0.rw           = 1'b1;
        bus0.mem_en       = 1'b1;
        cyc();
        bus0.mem_en = 1'b0;
        bus0.rw     = 1'b0;
        check("zw_store_ready", bus0.mem_ready, 1'b1);
        check("zw_store_busy", bus0.busy, 1'b1);
        cyc();
        check("zw_ready_end", bus0.mem_ready, 1'b0);
        bus0.mdr_write_en = 1'b1;
        cyc();
        bus0.mdr_write_en = 1'b0;
        bus0.mem_en       = 1'b1;
        cyc();
        bus0.mem_en = 1'b0;
        check("zw_load_ready", bus0.mem_ready, 1'b1);
        bus0.mdr_read_en = 1'b1;
        cyc();
        bus0.mdr_read_en = 1'b0;
        check("zw_load_data", bus0.mdr_q, 16'h4242);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
